// File: rtl/time_of_day.sv
// rtl/time_of_day.sv - time-of-day clock advanced by wraps of an upstream free-running counter
//
// A second elapses when the upstream counter wraps from TICK_LIMIT to 0; the
// hour/min/sec registers then advance by one. Software may overwrite the time
// through a valid/ready load port; loads are refused for the single cycle in
// which a second is detected, so a detected second is never lost.
//
// Optional feature macro: TIME_OF_DAY_ALARM_EN (adds an hour:min alarm).
//
// Ports:
//   clk            sole clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_count        combinational next-count value of the upstream counter
//   i_load_valid   request to set the time to i_load_hour:i_load_min:i_load_sec
//   o_load_ready   load accepted this cycle if i_load_valid
//   o_load_err     one-cycle pulse: accepted load was out of range
//   o_hour/min/sec current time, binary, registered
//   o_sec_tick     one-cycle pulse with every second advance
//   o_day_tick     one-cycle pulse on the 23:59:59 -> 00:00:00 advance
//   i_alarm_set, i_alarm_hour, i_alarm_min, o_alarm   (TIME_OF_DAY_ALARM_EN only)

module time_of_day #(
    parameter int COUNT_WIDTH = 32,
    parameter int TICK_LIMIT  = 2000000000
) (
    input  logic                   clk,
    input  logic                   i_reset,
    input  logic [COUNT_WIDTH-1:0] i_count,
    input  logic                   i_load_valid,
    input  logic [4:0]             i_load_hour,
    input  logic [5:0]             i_load_min,
    input  logic [5:0]             i_load_sec,
    output logic                   o_load_ready,
    output logic                   o_load_err,
    output logic [4:0]             o_hour,
    output logic [5:0]             o_min,
    output logic [5:0]             o_sec,
    output logic                   o_sec_tick,
    output logic                   o_day_tick
`ifdef TIME_OF_DAY_ALARM_EN
    ,
    input  logic                   i_alarm_set,
    input  logic [4:0]             i_alarm_hour,
    input  logic [5:0]             i_alarm_min,
    output logic                   o_alarm
`endif
);

    localparam logic [COUNT_WIDTH-1:0] TICK_LIMIT_C = COUNT_WIDTH'(TICK_LIMIT);

    logic [COUNT_WIDTH-1:0] r_prev_count_q, r_prev_count_d;
    logic [4:0]             hour_q, hour_d;
    logic [5:0]             min_q, min_d;
    logic [5:0]             sec_q, sec_d;
    logic                   sec_tick_q, sec_tick_d;
    logic                   day_tick_q, day_tick_d;
    logic                   load_err_q, load_err_d;

    logic sec_detect;
    logic load_accept;
    logic load_in_range;
    logic wrap_sec, wrap_min, wrap_hour;

`ifdef TIME_OF_DAY_ALARM_EN
    logic [4:0] alarm_hour_q, alarm_hour_d;
    logic [5:0] alarm_min_q, alarm_min_d;
    logic       alarm_armed_q, alarm_armed_d;
    logic       alarm_q, alarm_d;
`endif

    always_comb begin
        // Only a genuine wrap from TICK_LIMIT counts; other returns to 0
        // (upstream resets) are ignored.
        sec_detect    = (r_prev_count_q == TICK_LIMIT_C) && (i_count == '0);
        load_accept   = i_load_valid && !sec_detect;
        load_in_range = (i_load_hour <= 5'd23) && (i_load_min <= 6'd59) && (i_load_sec <= 6'd59);

        wrap_sec  = (sec_q == 6'd59);
        wrap_min  = (min_q == 6'd59);
        wrap_hour = (hour_q == 5'd23);

        r_prev_count_d = i_count;
        hour_d         = hour_q;
        min_d          = min_q;
        sec_d          = sec_q;
        sec_tick_d     = 1'b0;
        day_tick_d     = 1'b0;
        load_err_d     = 1'b0;

        if (sec_detect) begin
            sec_tick_d = 1'b1;
            sec_d      = wrap_sec ? 6'd0 : sec_q + 6'd1;
            if (wrap_sec) begin
                min_d = wrap_min ? 6'd0 : min_q + 6'd1;
            end
            if (wrap_sec && wrap_min) begin
                hour_d = wrap_hour ? 5'd0 : hour_q + 5'd1;
            end
            day_tick_d = wrap_sec && wrap_min && wrap_hour;
        end else if (load_accept) begin
            if (load_in_range) begin
                hour_d = i_load_hour;
                min_d  = i_load_min;
                sec_d  = i_load_sec;
            end else begin
                load_err_d = 1'b1;
            end
        end
    end

`ifdef TIME_OF_DAY_ALARM_EN
    always_comb begin
        alarm_hour_d  = alarm_hour_q;
        alarm_min_d   = alarm_min_q;
        alarm_armed_d = alarm_armed_q;
        // Compared against the stored alarm, so a set in the same cycle as
        // an advance takes effect from the next advance onward.
        alarm_d = sec_detect && alarm_armed_q && (sec_d == 6'd0)
                  && (min_d == alarm_min_q) && (hour_d == alarm_hour_q);
        if (i_alarm_set && (i_alarm_hour <= 5'd23) && (i_alarm_min <= 6'd59)) begin
            alarm_hour_d  = i_alarm_hour;
            alarm_min_d   = i_alarm_min;
            alarm_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            alarm_hour_q  <= 5'd0;
            alarm_min_q   <= 6'd0;
            alarm_armed_q <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            alarm_hour_q  <= alarm_hour_d;
            alarm_min_q   <= alarm_min_d;
            alarm_armed_q <= alarm_armed_d;
            alarm_q       <= alarm_d;
        end
    end

    assign o_alarm = alarm_q;
`endif

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            r_prev_count_q <= '0;
            hour_q         <= 5'd0;
            min_q          <= 6'd0;
            sec_q          <= 6'd0;
            sec_tick_q     <= 1'b0;
            day_tick_q     <= 1'b0;
            load_err_q     <= 1'b0;
        end else begin
            r_prev_count_q <= r_prev_count_d;
            hour_q         <= hour_d;
            min_q          <= min_d;
            sec_q          <= sec_d;
            sec_tick_q     <= sec_tick_d;
            day_tick_q     <= day_tick_d;
            load_err_q     <= load_err_d;
        end
    end

    // With r_prev_count_q cleared, detection is impossible during reset,
    // so ready is naturally 1 there.
    assign o_load_ready = !sec_detect;
    assign o_load_err   = load_err_q;
    assign o_hour       = hour_q;
    assign o_min        = min_q;
    assign o_sec        = sec_q;
    assign o_sec_tick   = sec_tick_q;
    assign o_day_tick   = day_tick_q;

endmodule

// File: tb/tb_time_of_day.sv
// tb/tb_time_of_day.sv - self-checking bench for time_of_day against a seconds-of-day model

module tb_time_of_day;

    localparam int CW = 8;
    localparam int TL = 4;

    logic          clk;
    logic          i_reset;
    logic [CW-1:0] i_count;
    logic          i_load_valid;
    logic [4:0]    i_load_hour;
    logic [5:0]    i_load_min;
    logic [5:0]    i_load_sec;
    logic          o_load_ready;
    logic          o_load_err;
    logic [4:0]    o_hour;
    logic [5:0]    o_min;
    logic [5:0]    o_sec;
    logic          o_sec_tick;
    logic          o_day_tick;
`ifdef TIME_OF_DAY_ALARM_EN
    logic          i_alarm_set;
    logic [4:0]    i_alarm_hour;
    logic [5:0]    i_alarm_min;
    logic          o_alarm;
`endif

    time_of_day #(.COUNT_WIDTH(CW), .TICK_LIMIT(TL)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_count      (i_count),
        .i_load_valid (i_load_valid),
        .i_load_hour  (i_load_hour),
        .i_load_min   (i_load_min),
        .i_load_sec   (i_load_sec),
        .o_load_ready (o_load_ready),
        .o_load_err   (o_load_err),
        .o_hour       (o_hour),
        .o_min        (o_min),
        .o_sec        (o_sec),
        .o_sec_tick   (o_sec_tick),
        .o_day_tick   (o_day_tick)
`ifdef TIME_OF_DAY_ALARM_EN
        ,
        .i_alarm_set  (i_alarm_set),
        .i_alarm_hour (i_alarm_hour),
        .i_alarm_min  (i_alarm_min),
        .o_alarm      (o_alarm)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as seconds since midnight.
    int m_tod  = 0;
    int m_prev = 0;
    int cur_cnt = 0;
    bit m_armed = 0;
    int m_ah = 0;
    int m_am = 0;
    bit a_set = 0;
    int a_h = 0;
    int a_m = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_time(input string tag);
        check({tag, "_hour"}, 32'(o_hour), 32'(m_tod / 3600));
        check({tag, "_min"},  32'(o_min),  32'((m_tod / 60) % 60));
        check({tag, "_sec"},  32'(o_sec),  32'(m_tod % 60));
    endtask

    // One clock: apply inputs, check ready before the edge, then advance the
    // model and check every registered output after the edge.
    task automatic cycle(input int cnt, input bit lv, input int lh, input int lm, input int ls);
        bit det, exp_tick, exp_day, exp_err, exp_alarm;
        i_count      = CW'(cnt);
        i_load_valid = lv;
        i_load_hour  = 5'(lh);
        i_load_min   = 6'(lm);
        i_load_sec   = 6'(ls);
`ifdef TIME_OF_DAY_ALARM_EN
        i_alarm_set  = a_set;
        i_alarm_hour = 5'(a_h);
        i_alarm_min  = 6'(a_m);
`endif
        #1;
        det = (m_prev == TL) && (cnt == 0);
        check("load_ready", 32'(o_load_ready), 32'(!det));
        @(posedge clk);
        #1;
        exp_tick = det; exp_day = 0; exp_err = 0; exp_alarm = 0;
        if (det) begin
            exp_day   = (m_tod == 86399);
            m_tod     = (m_tod + 1) % 86400;
            exp_alarm = m_armed && (m_tod == m_ah * 3600 + m_am * 60);
        end else if (lv) begin
            if (lh < 24 && lm < 60 && ls < 60) m_tod = lh * 3600 + lm * 60 + ls;
            else exp_err = 1;
        end
        if (a_set && a_h < 24 && a_m < 60) begin
            m_armed = 1; m_ah = a_h; m_am = a_m;
        end
        m_prev  = cnt;
        cur_cnt = cnt;
        check_time("time");
        check("sec_tick", 32'(o_sec_tick), 32'(exp_tick));
        check("day_tick", 32'(o_day_tick), 32'(exp_day));
        check("load_err", 32'(o_load_err), 32'(exp_err));
`ifdef TIME_OF_DAY_ALARM_EN
        check("alarm", 32'(o_alarm), 32'(exp_alarm));
`endif
    endtask

    task automatic count_up_to_tick();
        for (int c = 1; c <= TL; c++) cycle(c, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_count = '0;
        i_load_valid = 1'b0;
        i_load_hour = '0;
        i_load_min = '0;
        i_load_sec = '0;
`ifdef TIME_OF_DAY_ALARM_EN
        i_alarm_set = 1'b0;
        i_alarm_hour = '0;
        i_alarm_min = '0;
`endif
        @(posedge clk);
        #1;
        check_time("reset");
        check("reset_sec_tick", 32'(o_sec_tick), 32'd0);
        check("reset_day_tick", 32'(o_day_tick), 32'd0);
        check("reset_load_err", 32'(o_load_err), 32'd0);
        check("reset_ready",    32'(o_load_ready), 32'd1);
        i_reset = 1'b0;

        // Basic counter wrap 0,1,2,3,4,0: one second after the 4->0 sample.
        cycle(0, 0, 0, 0, 0);
        count_up_to_tick();
        check("first_tick_sec", 32'(o_sec), 32'd1);
        check("first_tick_pulse", 32'(o_sec_tick), 32'd1);
        cycle(1, 0, 0, 0, 0);
        check("tick_one_cycle", 32'(o_sec_tick), 32'd0);

        // Day rollover.
        cycle(2, 1, 23, 59, 59);
        cycle(3, 0, 0, 0, 0);
        cycle(4, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("rollover_day_tick", 32'(o_day_tick), 32'd1);
        check("rollover_hour", 32'(o_hour), 32'd0);

        // Out-of-range load then a good load.
        cycle(1, 1, 12, 60, 0);
        check("bad_load_err", 32'(o_load_err), 32'd1);
        cycle(2, 1, 12, 34, 56);
        check("good_load_min", 32'(o_min), 32'd34);

        // Load held across the detection cycle.
        cycle(3, 0, 0, 0, 0);
        cycle(4, 1, 1, 2, 3);
        cycle(0, 1, 1, 2, 3);
        cycle(1, 1, 1, 2, 3);
        check("held_load_sec", 32'(o_sec), 32'd3);

        // Upstream reset from 3 to 0 is not a second.
        cycle(2, 0, 0, 0, 0);
        cycle(3, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("early_wrap_no_tick", 32'(o_sec_tick), 32'd0);

        // Asynchronous reset mid-count at 05:06:07, with a wrap pending.
        cycle(1, 1, 5, 6, 7);
        cycle(2, 0, 0, 0, 0);
        cycle(3, 0, 0, 0, 0);
        cycle(4, 0, 0, 0, 0);
        #2;
        i_reset = 1'b1;
        #1;
        m_tod = 0; m_prev = 0; m_armed = 0; m_ah = 0; m_am = 0;
        check_time("async_reset");
        check("async_reset_ready", 32'(o_load_ready), 32'd1);
        @(posedge clk);
        #2;
        i_reset = 1'b0;
        cycle(0, 0, 0, 0, 0);
        check("post_reset_no_tick", 32'(o_sec_tick), 32'd0);

`ifdef TIME_OF_DAY_ALARM_EN
        a_set = 1; a_h = 0; a_m = 1;
        cycle(1, 1, 0, 0, 59);
        a_set = 0;
        cycle(2, 0, 0, 0, 0);
        cycle(3, 0, 0, 0, 0);
        cycle(4, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("alarm_pulse", 32'(o_alarm), 32'd1);
        cycle(1, 0, 0, 0, 0);
        check("alarm_single", 32'(o_alarm), 32'd0);
`endif

        // Randomized traffic: mostly clean counting, some glitches and loads.
        for (int i = 0; i < 3000; i++) begin
            int r, nxt, lh, lm, ls;
            bit lv;
            r = int'($urandom_range(0, 19));
            if (r < 16)      nxt = (cur_cnt >= TL) ? 0 : cur_cnt + 1;
            else if (r < 18) nxt = 0;
            else             nxt = int'($urandom_range(0, 255));
            lv = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                lh = 23; lm = 59; ls = int'($urandom_range(55, 59));
            end else begin
                lh = int'($urandom_range(0, 25));
                lm = int'($urandom_range(0, 61));
                ls = int'($urandom_range(0, 61));
            end
            cycle(nxt, lv, lh, lm, ls);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
